id_ex_stage_reg: RTL and testbench

//  - ID/EX pipeline register directly downstream of the register-file read: captures RsData/RtData, register

---
 rtl/id_ex_stage_reg_if.sv | 67 ++++++
 rtl/id_ex_stage_reg.sv | 111 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ============================================================================
//  Module   : id_ex_stage_reg_if
//  Purpose  : ID-side inputs and EX-side outputs of the ID/EX pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [3:0]        alu_op;
    logic              flush;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_addr;
    logic [DATA_W-1:0] wb_write_data;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_write_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, rs_data, rt_data, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op,
               flush, wb_reg_write, wb_write_addr, wb_write_data,
        input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_write_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
               ex_alu_op, stall, stall_count
    );

    modport slave (
        input  id_valid, rs_data, rt_data, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op,
               flush, wb_reg_write, wb_write_addr, wb_write_data,
        output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_write_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
               ex_alu_op, stall, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
//  Module   : id_ex_stage_reg
//  Purpose  : ID/EX pipeline register with load-use stall, branch flush and a
//             saturating stall counter. Define IDEX_WB_BYPASS_EN to forward a
//             same-cycle write-back into the captured operands.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    id_ex_stage_reg_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_write_addr;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic              r_ex_mem_write;
    logic              r_ex_mem_to_reg;
    logic              r_ex_alu_src;
    logic [3:0]        r_ex_alu_op;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_stall;
    logic [DATA_W-1:0] w_rs_cap;
    logic [DATA_W-1:0] w_rt_cap;

    // A load in EX whose destination is read by the instruction in ID.
    assign w_stall = bus.id_valid & r_ex_valid & r_ex_mem_read & ~bus.flush &
                     ((r_ex_write_addr == bus.rs) | (r_ex_write_addr == bus.rt));

`ifdef IDEX_WB_BYPASS_EN
    assign w_rs_cap = (bus.wb_reg_write && (bus.wb_write_addr == bus.rs)) ? bus.wb_write_data : bus.rs_data;
    assign w_rt_cap = (bus.wb_reg_write && (bus.wb_write_addr == bus.rt)) ? bus.wb_write_data : bus.rt_data;
`else
    assign w_rs_cap = bus.rs_data;
    assign w_rt_cap = bus.rt_data;
`endif

    always_ff @(posedge clk) begin
        if (reset || bus.flush || w_stall) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs_data    <= '0;
            r_ex_rt_data    <= '0;
            r_ex_imm        <= '0;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_ex_write_addr <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_alu_src    <= 1'b0;
            r_ex_alu_op     <= '0;
        end else begin
            r_ex_valid      <= bus.id_valid;
            r_ex_rs_data    <= w_rs_cap;
            r_ex_rt_data    <= w_rt_cap;
            r_ex_imm        <= bus.imm;
            r_ex_rs         <= bus.rs;
            r_ex_rt         <= bus.rt;
            r_ex_write_addr <= bus.reg_dst ? bus.rd : bus.rt;
            // An empty ID slot must not carry side-effecting control into EX.
            r_ex_reg_write  <= bus.id_valid & bus.reg_write;
            r_ex_mem_read   <= bus.id_valid & bus.mem_read;
            r_ex_mem_write  <= bus.id_valid & bus.mem_write;
            r_ex_mem_to_reg <= bus.id_valid & bus.mem_to_reg;
            r_ex_alu_src    <= bus.id_valid & bus.alu_src;
            r_ex_alu_op     <= bus.id_valid ? bus.alu_op : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_rs_data    = r_ex_rs_data;
    assign bus.ex_rt_data    = r_ex_rt_data;
    assign bus.ex_imm        = r_ex_imm;
    assign bus.ex_rs         = r_ex_rs;
    assign bus.ex_rt         = r_ex_rt;
    assign bus.ex_write_addr = r_ex_write_addr;
    assign bus.ex_reg_write  = r_ex_reg_write;
    assign bus.ex_mem_read   = r_ex_mem_read;
    assign bus.ex_mem_write  = r_ex_mem_write;
    assign bus.ex_mem_to_reg = r_ex_mem_to_reg;
    assign bus.ex_alu_src    = r_ex_alu_src;
    assign bus.ex_alu_op     = r_ex_alu_op;
    assign bus.stall         = w_stall;
    assign bus.stall_count   = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
//  Module   : tb_id_ex_stage_reg
//  Purpose  : Directed checks of id_ex_stage_reg (default and CNT_W=4 instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;
    logic clk;
    logic reset;
    int   checks;
    int   passed;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus  ();
    id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  bus2 ();

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic idle1();
        bus.id_valid = 0; bus.rs_data = 0; bus.rt_data = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
        bus.imm = 0; bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_to_reg = 0;
        bus.alu_src = 0; bus.reg_dst = 0; bus.alu_op = 0; bus.flush = 0;
        bus.wb_reg_write = 0; bus.wb_write_addr = 0; bus.wb_write_data = 0;
    endtask

    task automatic idle2();
        bus2.id_valid = 0; bus2.rs_data = 0; bus2.rt_data = 0; bus2.rs = 0; bus2.rt = 0; bus2.rd = 0;
        bus2.imm = 0; bus2.reg_write = 0; bus2.mem_read = 0; bus2.mem_write = 0; bus2.mem_to_reg = 0;
        bus2.alu_src = 0; bus2.reg_dst = 0; bus2.alu_op = 0; bus2.flush = 0;
        bus2.wb_reg_write = 0; bus2.wb_write_addr = 0; bus2.wb_write_data = 0;
    endtask

    // lw $rt, imm($rs): destination is rt (reg_dst=0)
    task automatic present_lw(input logic [4:0] rs, input logic [4:0] rt);
        idle1();
        bus.id_valid = 1; bus.rs = rs; bus.rt = rt; bus.rd = 5'd9; bus.reg_dst = 0;
        bus.mem_read = 1; bus.reg_write = 1; bus.mem_to_reg = 1; bus.alu_src = 1;
        bus.rs_data = 32'd11; bus.imm = 32'd4;
    endtask

    task automatic present_dep();
        idle1();
        bus.id_valid = 1; bus.rs = 5'd5; bus.rt = 5'd6; bus.rd = 5'd8; bus.reg_dst = 1;
        bus.reg_write = 1; bus.rs_data = 32'd55; bus.rt_data = 32'd66; bus.alu_op = 4'd3;
    endtask

    initial begin
        checks = 0;
        passed = 0;

        // Reset with random inputs
        reset = 1;
        bus.id_valid = 1'($urandom); bus.rs_data = $urandom; bus.rt_data = $urandom;
        bus.rs = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom); bus.imm = $urandom;
        bus.reg_write = 1'($urandom); bus.mem_read = 1; bus.mem_write = 1'($urandom);
        bus.mem_to_reg = 1'($urandom); bus.alu_src = 1'($urandom); bus.reg_dst = 1'($urandom);
        bus.alu_op = 4'($urandom); bus.flush = 0; bus.wb_reg_write = 1'($urandom);
        bus.wb_write_addr = 5'($urandom); bus.wb_write_data = $urandom;
        idle2();
        tick();
        tick();
        check("rst_valid",  32'(bus.ex_valid), 0);
        check("rst_rsdata", bus.ex_rs_data, 0);
        check("rst_rtdata", bus.ex_rt_data, 0);
        check("rst_imm",    bus.ex_imm, 0);
        check("rst_waddr",  32'(bus.ex_write_addr), 0);
        check("rst_ctrl",   32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                 bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op}), 0);
        check("rst_stall",  32'(bus.stall), 0);
        check("rst_cnt",    32'(bus.stall_count), 0);
        reset = 0;
        idle1();

        // Plain capture
        bus.id_valid = 1; bus.rs = 3; bus.rt = 4; bus.rd = 7; bus.rs_data = 30; bus.rt_data = 40;
        bus.reg_dst = 1; bus.alu_op = 2; bus.imm = 32'h1234; bus.reg_write = 1;
        #1 check("cap_nostall", 32'(bus.stall), 0);
        tick();
        check("cap_valid",  32'(bus.ex_valid), 1);
        check("cap_rsdata", bus.ex_rs_data, 30);
        check("cap_rtdata", bus.ex_rt_data, 40);
        check("cap_waddr",  32'(bus.ex_write_addr), 7);
        check("cap_aluop",  32'(bus.ex_alu_op), 2);
        check("cap_rs_rt",  32'({bus.ex_rs, bus.ex_rt}), {22'd0, 5'd3, 5'd4});
        check("cap_imm",    bus.ex_imm, 32'h1234);
        check("cap_regwr",  32'(bus.ex_reg_write), 1);

        // Load-use hazard: one stall cycle, bubble, then capture
        present_lw(5'd1, 5'd5);
        tick();
        check("lw_memread", 32'(bus.ex_mem_read), 1);
        check("lw_waddr",   32'(bus.ex_write_addr), 5);
        present_dep();
        #1 check("lu_stall", 32'(bus.stall), 1);
        tick();
        check("lu_bubble",  32'(bus.ex_valid), 0);
        check("lu_bub_mr",  32'(bus.ex_mem_read), 0);
        check("lu_cnt",     32'(bus.stall_count), 1);
        check("lu_unstall", 32'(bus.stall), 0);
        tick();
        check("lu_valid",   32'(bus.ex_valid), 1);
        check("lu_rs",      32'(bus.ex_rs), 5);
        check("lu_waddr",   32'(bus.ex_write_addr), 8);
        check("lu_rsdata",  bus.ex_rs_data, 55);
        check("lu_cnt2",    32'(bus.stall_count), 1);

        // Flush overrides a simultaneous hazard
        present_lw(5'd1, 5'd5);
        tick();
        present_dep();
        bus.flush = 1;
        #1 check("fl_stall", 32'(bus.stall), 0);
        tick();
        check("fl_valid",   32'(bus.ex_valid), 0);
        check("fl_regwr",   32'(bus.ex_reg_write), 0);
        check("fl_cnt",     32'(bus.stall_count), 1);

        // Reset in the middle of a stall
        present_lw(5'd1, 5'd5);
        tick();
        present_dep();
        #1 check("rs_stall_pre", 32'(bus.stall), 1);
        reset = 1;
        tick();
        reset = 0;
        check("rs_valid", 32'(bus.ex_valid), 0);
        check("rs_stall", 32'(bus.stall), 0);
        check("rs_cnt",   32'(bus.stall_count), 0);

        // Write-back bypass on rs and rt
        idle1();
        bus.id_valid = 1; bus.rs = 2; bus.rs_data = 20; bus.rt = 6; bus.rt_data = 60;
        bus.wb_reg_write = 1; bus.wb_write_addr = 2; bus.wb_write_data = 99;
        tick();
`ifdef IDEX_WB_BYPASS_EN
        check("byp_rs", bus.ex_rs_data, 99);
`else
        check("byp_rs", bus.ex_rs_data, 20);
`endif
        check("byp_rt_untouched", bus.ex_rt_data, 60);
        bus.wb_write_addr = 6;
        tick();
        check("byp_rs2", bus.ex_rs_data, 20);
`ifdef IDEX_WB_BYPASS_EN
        check("byp_rt", bus.ex_rt_data, 99);
`else
        check("byp_rt", bus.ex_rt_data, 60);
`endif
        idle1();

        // Saturation on the CNT_W=4 instance: lw r5 <- (r5) repeated stalls every other cycle
        bus2.id_valid = 1; bus2.rs = 5; bus2.rt = 5; bus2.reg_dst = 0; bus2.mem_read = 1;
        bus2.reg_write = 1; bus2.mem_to_reg = 1;
        tick();
        check("sat_lw_in_ex", 32'(bus2.ex_mem_read), 1);
        for (int i = 0; i < 14; i++) begin
            tick();
            tick();
        end
        check("sat_cnt14", 32'(bus2.stall_count), 14);
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
        end
        check("sat_cnt15", 32'(bus2.stall_count), 15);
        check("sat_stall_again", 32'(bus2.stall), 1);
        tick();
        check("sat_hold", 32'(bus2.stall_count), 15);
        idle2();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
